// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, step op decode, default width.
package booth_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_e;

   // Radix-2 Booth recoding of the pair {Q[0], q_1}.
   function automatic booth_op_e booth_op(input logic q0, input logic q1);
      case ({q0, q1})
         2'b10:   return OP_SUB;
         2'b01:   return OP_ADD;
         default: return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand/product handshake bundle between source, multiplier and consumer.
interface booth_seq_ctrl_if #(parameter int WIDTH = booth_pkg::DEF_WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 abort;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_p;
   logic                 busy;

   modport master (
      output in_valid, in_a, in_b, abort, out_ready,
      input  in_ready, out_valid, out_p, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, abort, out_ready,
      output in_ready, out_valid, out_p, busy
   );

endinterface

// File: rtl/booth_iter_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic
// right shift of {A,Q,q_1}. Purely combinational; A and M carry one guard bit.
module booth_iter_step
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a_i;
      case (booth_op(q_i[0], q1_i))
         OP_ADD:  sum = a_i + m_i;
         OP_SUB:  sum = a_i - m_i;
         default: sum = a_i;
      endcase
      a_o  = {sum[WIDTH], sum[WIDTH:1]};
      q_o  = {sum[0], q_i[WIDTH-1:1]};
      q1_o = q_i[0];
   end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative signed Booth multiplier: accept one pair, run WIDTH shared add/shift steps,
// then hold the registered product until the consumer takes it or abort cancels it.
module booth_seq_ctrl
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   booth_seq_ctrl_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e               state_q;
   logic [WIDTH:0]       a_q;
   logic [WIDTH-1:0]     q_q;
   logic [WIDTH:0]       m_q;
   logic                 q1_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   p_q;
   logic                 out_valid_q;
   logic                 in_ready_q;
   logic                 busy_q;

   logic [WIDTH:0]       a_d;
   logic [WIDTH-1:0]     q_d;
   logic                 q1_d;

   booth_iter_step #(.WIDTH(WIDTH)) u_step (
      .a_i  (a_q),
      .q_i  (q_q),
      .q1_i (q1_q),
      .m_i  (m_q),
      .a_o  (a_d),
      .q_o  (q_d),
      .q1_o (q1_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         q1_q        <= 1'b0;
         cnt_q       <= '0;
         p_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= RUN;
                  a_q        <= '0;
                  q_q        <= bus.in_a;
                  m_q        <= {bus.in_b[WIDTH-1], bus.in_b};
                  q1_q       <= 1'b0;
                  cnt_q      <= CNT_W'(WIDTH);
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  a_q   <= a_d;
                  q_q   <= q_d;
                  q1_q  <= q1_d;
                  cnt_q <= cnt_q - 1'b1;
                  // Guard bit of A is dropped here; the product always fits 2*WIDTH bits.
                  if (cnt_q == CNT_W'(1)) begin
                     state_q     <= DONE;
                     p_q         <= {a_d[WIDTH-1:0], q_d};
                     out_valid_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.abort || bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = p_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Randomized self-checking bench for booth_seq_ctrl against a signed-multiply reference.
module tb_booth_seq_ctrl;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   booth_seq_ctrl_if #(.WIDTH(W)) bif ();

   booth_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic signed [15:0] pr;
      sa = $signed(a);
      sb = $signed(b);
      pr = sa * sb;
      return pr;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!bif.in_ready && w < 30) begin
         tick();
         w++;
      end
      chk("ready_before_accept", 32'(bif.in_ready), 32'd1);
   endtask

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
      wait_ready();
      bif.in_a     = a;
      bif.in_b     = b;
      bif.in_valid = 1'b1;
      tick();
      bif.in_valid = 1'b0;
   endtask

   // Full transaction with 'hold' cycles of consumer backpressure in DONE.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [15:0] exp;
      int          lat;
      exp = ref_mul(a, b);
      accept(a, b);
      chk("busy_after_accept", 32'(bif.busy), 32'd1);
      lat = 0;
      while (!bif.out_valid && lat < 40) begin
         bif.in_valid = 1'($urandom_range(0, 1));
         bif.in_a     = W'($urandom);
         tick();
         lat++;
      end
      bif.in_valid = 1'b0;
      chk("latency", 32'(lat), 32'(W));
      chk("product", 32'(bif.out_p), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         bif.in_valid = 1'b1;
         tick();
         chk("hold_valid", 32'(bif.out_valid), 32'd1);
         chk("hold_product", 32'(bif.out_p), 32'(exp));
         chk("hold_in_ready", 32'(bif.in_ready), 32'd0);
      end
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      tick();
      bif.out_ready = 1'b0;
      chk("post_handoff_valid", 32'(bif.out_valid), 32'd0);
      chk("post_handoff_ready", 32'(bif.in_ready), 32'd1);
      chk("post_handoff_busy", 32'(bif.busy), 32'd0);
      chk("idle_holds_product", 32'(bif.out_p), 32'(exp));
   endtask

   task automatic expect_no_valid(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (bif.out_valid) seen++;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bif.in_valid  = 1'b0;
      bif.in_a      = '0;
      bif.in_b      = '0;
      bif.abort     = 1'b0;
      bif.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_out_p", 32'(bif.out_p), 32'd0);
      rst_n = 1'b1;
      tick();

      run_op(8'd3, 8'd5, 0);
      run_op(8'h80, 8'h80, 0);
      run_op(8'd127, 8'h80, 1);
      run_op(8'hFF, 8'hFF, 0);
      run_op(8'd7, 8'hF7, 5);
      run_op(8'd0, 8'd0, 0);
      run_op(8'd0, 8'h80, 2);
      run_op(8'h80, 8'd127, 0);

      // Abort during the RUN phase, before the 4th step edge.
      accept(8'd5, 8'd7);
      tick();
      tick();
      tick();
      bif.abort = 1'b1;
      tick();
      bif.abort = 1'b0;
      chk("abort_run_busy", 32'(bif.busy), 32'd0);
      chk("abort_run_ready", 32'(bif.in_ready), 32'd1);
      chk("abort_run_valid", 32'(bif.out_valid), 32'd0);
      expect_no_valid("abort_run_no_product", 12);
      run_op(8'd2, 8'd2, 0);

      // Abort in DONE wins over a simultaneous out_ready.
      accept(8'd9, 8'd9);
      for (int i = 0; i < W; i++) tick();
      chk("done_reached", 32'(bif.out_valid), 32'd1);
      bif.abort     = 1'b1;
      bif.out_ready = 1'b1;
      tick();
      bif.abort     = 1'b0;
      bif.out_ready = 1'b0;
      chk("abort_done_valid", 32'(bif.out_valid), 32'd0);
      chk("abort_done_ready", 32'(bif.in_ready), 32'd1);

      // Asynchronous reset in the middle of RUN.
      accept(8'd11, 8'd13);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bif.out_valid), 32'd0);
      chk("arst_busy", 32'(bif.busy), 32'd0);
      chk("arst_out_p", 32'(bif.out_p), 32'd0);
      #2;
      rst_n = 1'b1;
      chk("arst_ready", 32'(bif.in_ready), 32'd1);
      expect_no_valid("arst_no_stale", 12);
      run_op(8'hF0, 8'd3, 0);

      for (int n = 0; n < 300; n++) begin
         run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
